// File: rtl/testio_arb_if.sv
// ---------------------------------------------------------------------------
// testio_arb_if
//   Bundle of the requester-side and slave-side memory handshakes around the
//   testio arbiter. One instance carries all NREQ requester lanes plus the
//   single testio slave port.
//
//   Payload types (local to the interface):
//     mem_req_t  : we, be[3:0], addr[31:0], wdata[31:0]
//     mem_resp_t : resp_data[31:0]
//
//   Signals:
//     s_req_valid[NREQ]  / s_req_ready[NREQ] / s_req[NREQ]  requester requests
//     s_resp_valid[NREQ] / s_resp_ready[NREQ] / s_resp      requester responses
//     m_req_valid / m_req_ready / m_req                     request to slave
//     m_resp_valid / m_resp_ready / m_resp                  response from slave
//
//   Modports:
//     slave  : the arbiter's view
//     master : the environment's view (requesters and the testio slave)
// ---------------------------------------------------------------------------
interface testio_arb_if #(
    parameter int NREQ = 3
);
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] resp_data;
    } mem_resp_t;

    logic [NREQ-1:0] s_req_valid;
    logic [NREQ-1:0] s_req_ready;
    mem_req_t        s_req [NREQ];
    logic [NREQ-1:0] s_resp_valid;
    logic [NREQ-1:0] s_resp_ready;
    mem_resp_t       s_resp;

    logic            m_req_valid;
    logic            m_req_ready;
    mem_req_t        m_req;
    logic            m_resp_valid;
    logic            m_resp_ready;
    mem_resp_t       m_resp;

    modport slave (
        input  s_req_valid, s_req, s_resp_ready,
        input  m_req_ready, m_resp_valid, m_resp,
        output s_req_ready, s_resp_valid, s_resp,
        output m_req_valid, m_req, m_resp_ready
    );

    modport master (
        output s_req_valid, s_req, s_resp_ready,
        output m_req_ready, m_resp_valid, m_resp,
        input  s_req_ready, s_resp_valid, s_resp,
        input  m_req_valid, m_req, m_resp_ready
    );
endinterface

// File: rtl/testio_arb.sv
// ---------------------------------------------------------------------------
// testio_arb
//   Round-robin arbiter sharing the single testio slave memory port among
//   NREQ requesters. One outstanding transaction at a time; the response is
//   routed back to the lane that was granted.
//
//   Optional feature macro: TI_ARB_TIMEOUT_EN
//     Adds a response timeout (TIMEOUT cycles). On expiry the granted lane
//     receives 32'hDEAD_BEEF, arb_err_o pulses, and the late slave response
//     is drained before the next grant. Without the macro ARB_WAIT waits
//     indefinitely and arb_err_o is tied low.
//
//   Ports:
//     ti_clk_i     clock
//     ti_rstn_i    asynchronous active-low reset
//     bus          testio_arb_if.slave (requester lanes + slave port)
//     arb_busy_o   high whenever the FSM is not in ARB_IDLE
//     arb_grant_o  current (or last) grant index
//     arb_err_o    one-cycle timeout pulse
// ---------------------------------------------------------------------------
module testio_arb #(
    parameter int NREQ    = 3,
    parameter int GW      = $clog2(NREQ),
    parameter int TIMEOUT = 1024
) (
    input  logic          ti_clk_i,
    input  logic          ti_rstn_i,
    testio_arb_if.slave   bus,
    output logic          arb_busy_o,
    output logic [GW-1:0] arb_grant_o,
    output logic          arb_err_o
);

    // Elaboration-time sanity check of the configuration.
    if (NREQ < 2 || NREQ > 8 || GW < $clog2(NREQ) || TIMEOUT < 2) begin : g_param_check
        $error("testio_arb: illegal parameter combination");
    end

`ifdef TI_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {
        ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_ERR, ARB_DRAIN
    } arb_state_t;
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_reg;
`else
    typedef enum logic [1:0] {
        ARB_IDLE, ARB_REQ, ARB_WAIT
    } arb_state_t;
`endif

    localparam logic [GW:0] NREQ_W = (GW + 1)'(NREQ);

    arb_state_t    state_reg;
    logic [GW-1:0] grant_reg;
    logic [GW-1:0] rr_ptr_reg;
    logic          busy_reg;
    logic          err_reg;

    // Round-robin pick: rotate the request vector so rr_ptr sits at bit 0,
    // take the lowest set bit, then rotate the offset back.
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [GW-1:0]     pick_off;
    logic [GW:0]       pick_sum;
    logic [GW-1:0]     pick_idx;
    logic              any_req;
    logic [GW-1:0]     grant_inc;

    assign req_dbl = {bus.s_req_valid, bus.s_req_valid};
    assign req_rot = NREQ'(req_dbl >> rr_ptr_reg);
    assign any_req = |req_rot;

    always_comb begin
        pick_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_off = GW'(k);
            end
        end
    end

    assign pick_sum  = {1'b0, rr_ptr_reg} + {1'b0, pick_off};
    assign pick_idx  = (pick_sum >= NREQ_W) ? GW'(pick_sum - NREQ_W) : GW'(pick_sum);
    assign grant_inc = (grant_reg == GW'(NREQ - 1)) ? '0 : grant_reg + 1'b1;

    always_ff @(posedge ti_clk_i or negedge ti_rstn_i) begin
        if (!ti_rstn_i) begin
            state_reg  <= ARB_IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b0;
`ifdef TI_ARB_TIMEOUT_EN
            cnt_reg    <= '0;
`endif
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_reg <= pick_idx;
                        state_reg <= ARB_REQ;
                        busy_reg  <= 1'b1;
                    end
                end
                ARB_REQ: begin
                    if (bus.m_req_ready) begin
                        state_reg <= ARB_WAIT;
`ifdef TI_ARB_TIMEOUT_EN
                        cnt_reg   <= '0;
`endif
                    end
                end
                ARB_WAIT: begin
                    if (bus.m_resp_valid && bus.s_resp_ready[grant_reg]) begin
                        rr_ptr_reg <= grant_inc;
                        state_reg  <= ARB_IDLE;
                        busy_reg   <= 1'b0;
                    end
`ifdef TI_ARB_TIMEOUT_EN
                    // A stalled-but-valid response (lane backpressure) does
                    // not count towards the timeout.
                    else if (!bus.m_resp_valid) begin
                        if (cnt_reg == CW'(TIMEOUT - 1)) begin
                            state_reg <= ARB_ERR;
                            err_reg   <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
`endif
                end
`ifdef TI_ARB_TIMEOUT_EN
                ARB_ERR: begin
                    if (bus.s_resp_ready[grant_reg]) begin
                        state_reg <= ARB_DRAIN;
                    end
                end
                ARB_DRAIN: begin
                    // The late slave response is swallowed here.
                    if (bus.m_resp_valid) begin
                        rr_ptr_reg <= grant_inc;
                        state_reg  <= ARB_IDLE;
                        busy_reg   <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_reg <= ARB_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Request forwarding and response pass-through.
    always_comb begin
        bus.m_req_valid            = (state_reg == ARB_REQ);
        bus.m_req                  = bus.s_req[grant_reg];
        bus.m_resp_ready           = 1'b0;
        bus.s_resp.resp_data       = 32'hFFFF_FFFF;
        case (state_reg)
            ARB_WAIT: begin
                bus.m_resp_ready = bus.s_resp_ready[grant_reg];
                bus.s_resp       = bus.m_resp;
            end
`ifdef TI_ARB_TIMEOUT_EN
            ARB_ERR: begin
                bus.s_resp.resp_data = 32'hDEAD_BEEF;
            end
            ARB_DRAIN: begin
                bus.m_resp_ready = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        logic lane_sel;
        assign lane_sel = (grant_reg == GW'(gi));
        assign bus.s_req_ready[gi] = lane_sel && (state_reg == ARB_REQ) && bus.m_req_ready;
`ifdef TI_ARB_TIMEOUT_EN
        assign bus.s_resp_valid[gi] = lane_sel &&
                                      (((state_reg == ARB_WAIT) && bus.m_resp_valid) ||
                                       (state_reg == ARB_ERR));
`else
        assign bus.s_resp_valid[gi] = lane_sel && (state_reg == ARB_WAIT) && bus.m_resp_valid;
`endif
    end

    assign arb_busy_o  = busy_reg;
    assign arb_grant_o = grant_reg;
`ifdef TI_ARB_TIMEOUT_EN
    assign arb_err_o   = err_reg;
`else
    assign arb_err_o   = 1'b0;
`endif

    // A granted requester must keep valid and payload stable until accepted.
    a_req_held: assert property (@(posedge ti_clk_i) disable iff (!ti_rstn_i)
        (state_reg == ARB_REQ) |-> bus.s_req_valid[grant_reg]);

    a_req_stable: assert property (@(posedge ti_clk_i) disable iff (!ti_rstn_i)
        (state_reg == ARB_REQ && !bus.m_req_ready) |=> $stable(bus.m_req));

endmodule

// File: doc/testio_arb.md
Name: testio_arb

Overview:
- Round-robin arbiter that shares the single testio slave memory port among NREQ memory-mapped requesters, for example the core data port, the debug module and the DMA.
- Sits between the requesters' mem_req/mem_resp interfaces and the testio slave's mem interface.
- Runs entirely in the testio clock domain.
- Allows one outstanding transaction at a time.
- Routes each response back to the requester that was granted.

Parameters:
- NREQ, 3, number of requesters (2..8).
- GW, $clog2(NREQ), width of the grant index.
- TIMEOUT, 1024, response timeout in ti_clk_i cycles (used only with TI_ARB_TIMEOUT_EN).

Ports:
- ti_clk_i  in  1  clock
- ti_rstn_i  in  1  reset; asynchronous, active-low
- s_req_valid  in  NREQ  per-requester request valid
- s_req_ready  out  NREQ  per-requester request ready
- s_req  in  NREQ x mem_req_t  per-requester request payload
- s_resp_valid  out  NREQ  per-requester response valid
- s_resp_ready  in  NREQ  per-requester response ready
- s_resp  out  mem_resp_t  shared response payload; valid only for the lane whose s_resp_valid is set
- m_req_valid  out  1  request valid to the testio slave
- m_req_ready  in  1  request ready from the testio slave
- m_req  out  mem_req_t  request payload to the testio slave
- m_resp_valid  in  1  response valid from the testio slave
- m_resp_ready  out  1  response ready to the testio slave
- m_resp  in  mem_resp_t  response payload from the testio slave
- arb_busy_o  out  1  high while in any state other than ARB_IDLE
- arb_grant_o  out  GW  current grant index
- arb_err_o  out  1  one-cycle pulse on timeout (tied to 0 when TI_ARB_TIMEOUT_EN is undefined)

Behaviour:
- Reset: ti_rstn_i is asynchronous, active-low; clock is ti_clk_i. Reset values:
  - state = ARB_IDLE
  - grant = 0
  - rr_ptr = 0
  - all valid/ready outputs = 0
  - arb_err_o = 0
  - s_resp.resp_data = 32'hFFFF_FFFF
- Reset asserted mid-transaction aborts the transaction; the granted requester sees no response.
- ARB_IDLE:
  - If any s_req_valid is set, register grant = first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - Next state is ARB_REQ.
  - No ready is asserted in this state.
- ARB_REQ:
  - m_req_valid = 1 and m_req = s_req[grant].
  - s_req_ready[grant] = m_req_ready; all other s_req_ready = 0.
  - On m_req_valid && m_req_ready, go to ARB_WAIT.
  - A requester must hold valid and payload stable until ready; withdrawing is a protocol violation and is covered by an assertion.
- ARB_WAIT:
  - Combinational pass-through: s_resp_valid[grant] = m_resp_valid, m_resp_ready = s_resp_ready[grant], s_resp = m_resp.
  - On m_resp_valid && m_resp_ready: rr_ptr = (grant+1) mod NREQ, next state ARB_IDLE.
- Latency:
  - Minimum 2 cycles from s_req_valid to the request handshake: 1 cycle in IDLE, then handshake in REQ.
  - 0 added cycles on the response path.
  - After a response handshake there is 1 idle cycle before the next grant.
- Requests arriving while busy wait; only one grant is ever active.
- Simultaneous requests: the winner is the first set bit at or after rr_ptr. A requester that keeps requesting cannot win twice in a row while another requester is waiting.
- s_resp_valid for non-granted lanes is always 0.
- arb_grant_o holds its last value while idle.

Optional Feature:
- Macro: TI_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to ARB_WAIT and increments each cycle without m_resp_valid.
  - When it reaches TIMEOUT-1, go to ARB_ERR.
- ARB_ERR:
  - s_resp_valid[grant] = 1 with resp_data = 32'hDEAD_BEEF.
  - arb_err_o pulses for 1 cycle on entry.
  - On s_resp_ready[grant], go to ARB_DRAIN.
- ARB_DRAIN:
  - m_resp_ready = 1; no s_resp_valid is asserted.
  - The first m_resp_valid is discarded; then rr_ptr advances and the next state is ARB_IDLE.
  - New requests are held off until the drain completes.
- When undefined: ARB_ERR and ARB_DRAIN and the counter are absent, arb_err_o = 0, and ARB_WAIT waits indefinitely.

Test Plan:
- Single requester 1 writes addr 0x100, data 0x12345678, slave ready after 3 cycles, response after 40 cycles -> arb_grant_o = 1, only s_req_ready[1] pulses, s_resp_valid[1] pulses once, lanes 0 and 2 stay 0.
- Requesters 0, 1 and 2 request continuously from reset -> grant order 0, 1, 2, 0, 1, 2; each response is routed to the lane that issued it.
- Response backpressure: s_resp_ready[0] = 0 for 5 cycles during ARB_WAIT -> m_resp_ready = 0 for those 5 cycles; a single handshake follows; state returns to ARB_IDLE 1 cycle later.
- Reset pulse while in ARB_WAIT -> all outputs return to reset values on the same cycle; the next request from lane 2 is granted normally.
- With TI_ARB_TIMEOUT_EN and TIMEOUT = 16, slave never responds:
  - arb_err_o pulses at WAIT+16.
  - Lane gets resp_data 0xDEADBEEF.
  - A late m_resp_valid is absorbed with no s_resp_valid.
  - Then the arbiter returns to ARB_IDLE.
- Lane 1 drops valid in ARB_IDLE before the grant is taken -> no transaction is issued and the arbiter stays in ARB_IDLE.
